// File: rtl/i2c_pkg.sv
// Purpose : constants shared by the I2C datapath and its controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: frame geometry, ACK slot positions, bit counter width,
//           frame type and the frame-building helper.
package i2c_pkg;

  localparam int FRAME_LEN  = 27;
  localparam int ACK_POS1   = 8;
  localparam int ACK_POS2   = 17;
  localparam int ACK_POS3   = 26;
  localparam int BITCOUNT_W = 5;

  typedef logic [FRAME_LEN-1:0] frame_t;

  // Lays out {byte2, ACK1, byte1, ACK2, byte0, ACK3}; ACK slots are 1 so
  // the controller releases SDA and the slave can drive its acknowledge.
  function automatic frame_t build_frame(input logic [23:0] payload);
    return {payload[23:16], 1'b1, payload[15:8], 1'b1, payload[7:0], 1'b1};
  endfunction

endpackage

// File: rtl/i2c_bitcount.sv
// Purpose : bit-position counter with clear and enable, wraps at 2^W-1.
// Latency : count updates on the CLK edge after clr/en.
// Backpressure: none; en simply holds the count when low.
// Ports   : CLK, rst (sync, active-high), clr (to 0, beats en), en (+1),
//           count (current value).
module i2c_bitcount
  import i2c_pkg::*;
(
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  output logic [BITCOUNT_W-1:0] count
);

  logic [BITCOUNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/i2c_datapath.sv
// Purpose : I2C write-frame datapath: 27-bit shift register, ACK capture,
//           frame status and completed-frame counter.
// Latency : LDEN -> first serial bit 1 cycle; rstACK -> done 1 cycle.
// Backpressure: none; sequencing is owned by the external controller.
// Ports   : CLK/reset; data_in + LDEN load a frame; SHEN/bitcountEN shift;
//           rstbitcount clears position; ldnACK1..3 capture SDA_in;
//           rstACK closes a frame; outputs bitcount, sda_oe, ack_status,
//           nack_err, done, xfer_cnt.
module i2c_datapath
  import i2c_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [23:0]           data_in,
  input  logic                  LDEN,
  input  logic                  SHEN,
  input  logic                  bitcountEN,
  input  logic                  rstbitcount,
  input  logic                  ldnACK1,
  input  logic                  ldnACK2,
  input  logic                  ldnACK3,
  input  logic                  rstACK,
  input  logic                  SDO,
  input  logic                  SDA_in,
  output logic [BITCOUNT_W-1:0] bitcount,
  output logic                  sda_oe,
  output logic [2:0]            ack_status,
  output logic                  nack_err,
  output logic                  done,
  output logic [CNT_W-1:0]      xfer_cnt
);

  frame_t           shreg_q, shreg_d;
  logic [2:0]       ack_q, ack_d;         // {a1,a2,a3}
  logic [2:0]       ack_status_q, ack_status_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic             serial_bit;

  i2c_bitcount u_bitcount (
    .CLK   (CLK),
    .rst   (reset),
    .clr   (rstbitcount | LDEN),
    .en    (bitcountEN),
    .count (bitcount)
  );

  always_comb begin
    shreg_d = shreg_q;
    if (LDEN) begin
      shreg_d = build_frame(data_in);
    end else if (SHEN && bitcountEN) begin
      shreg_d = {shreg_q[FRAME_LEN-2:0], 1'b1};
    end
  end

  // A capture strobe wins over a reload in the same cycle so a slave ACK
  // coinciding with the next frame's load is not lost.
  always_comb begin
    ack_d = ack_q;
    if (LDEN) ack_d = 3'b111;
    if (ldnACK1) ack_d[2] = SDA_in;
    if (ldnACK2) ack_d[1] = SDA_in;
    if (ldnACK3) ack_d[0] = SDA_in;
  end

  always_comb begin
    ack_status_d = ack_status_q;
    xfer_cnt_d   = xfer_cnt_q;
    done_d       = rstACK;
    if (rstACK) begin
      ack_status_d = ack_q;
      xfer_cnt_d   = xfer_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      shreg_q      <= '1;
      ack_q        <= 3'b111;
      ack_status_q <= 3'b000;
      done_q       <= 1'b0;
      xfer_cnt_q   <= '0;
    end else begin
      shreg_q      <= shreg_d;
      ack_q        <= ack_d;
      ack_status_q <= ack_status_d;
      done_q       <= done_d;
      xfer_cnt_q   <= xfer_cnt_d;
    end
  end

  assign serial_bit = SHEN ? shreg_q[FRAME_LEN-1] : SDO;
  // Open-drain: drive low only for a 0 bit, and never while in reset.
  assign sda_oe     = reset ? 1'b0 : ~serial_bit;
  assign ack_status = ack_status_q;
  assign nack_err   = |ack_status_q;
  assign done       = done_q;
  assign xfer_cnt   = xfer_cnt_q;

endmodule

// File: tb/tb_i2c_datapath.sv
module tb_i2c_datapath;

  logic        CLK = 1'b0;
  logic        reset;
  logic [23:0] data_in;
  logic        LDEN, SHEN, bitcountEN, rstbitcount;
  logic        ldnACK1, ldnACK2, ldnACK3, rstACK, SDO, SDA_in;
  logic [4:0]  bitcount;
  logic        sda_oe, nack_err, done;
  logic [2:0]  ack_status;
  logic [7:0]  xfer_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 CLK = ~CLK;

  i2c_datapath #(.CNT_W(8)) dut (
    .CLK(CLK), .reset(reset), .data_in(data_in), .LDEN(LDEN), .SHEN(SHEN),
    .bitcountEN(bitcountEN), .rstbitcount(rstbitcount),
    .ldnACK1(ldnACK1), .ldnACK2(ldnACK2), .ldnACK3(ldnACK3),
    .rstACK(rstACK), .SDO(SDO), .SDA_in(SDA_in),
    .bitcount(bitcount), .sda_oe(sda_oe), .ack_status(ack_status),
    .nack_err(nack_err), .done(done), .xfer_cnt(xfer_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    LDEN = 0; SHEN = 0; bitcountEN = 0; rstbitcount = 0;
    ldnACK1 = 0; ldnACK2 = 0; ldnACK3 = 0; rstACK = 0;
    SDO = 1; SDA_in = 1;
  endtask

  // Load a frame, shift all 27 positions checking serial bit and position,
  // capture the slave ACKs given in acks ({ack1,ack2,ack3}), then close it.
  task automatic run_frame(input logic [23:0] d, input logic [2:0] acks,
                           input logic [7:0] exp_cnt);
    logic [26:0] f;
    logic        e_oe;
    f = {d[23:16], 1'b1, d[15:8], 1'b1, d[7:0], 1'b1};
    data_in = d;
    LDEN = 1;
    tick();
    LDEN = 0;
    for (int i = 0; i < 27; i++) begin
      SHEN = 1; bitcountEN = 1;
      ldnACK1 = (i == 8); ldnACK2 = (i == 17); ldnACK3 = (i == 26);
      rstbitcount = (i == 26);
      SDA_in = (i == 8) ? acks[2] : (i == 17) ? acks[1] : (i == 26) ? acks[0] : 1'b1;
      #1;
      e_oe = ~f[26-i];
      chk("frame_bitcount", {27'd0, bitcount}, i);
      chk("frame_sda_oe", {31'd0, sda_oe}, {31'd0, e_oe});
      tick();
    end
    idle_inputs();
    #1;
    chk("bitcount_after_wrap", {27'd0, bitcount}, 32'd0);
    rstACK = 1;
    #1;
    chk("done_before_rstack_edge", {31'd0, done}, 32'd0);
    tick();
    rstACK = 0;
    #1;
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("ack_status", {29'd0, ack_status}, {29'd0, acks});
    chk("nack_err", {31'd0, nack_err}, {31'd0, |acks});
    chk("xfer_cnt", {24'd0, xfer_cnt}, {24'd0, exp_cnt});
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("nack_err_hold", {31'd0, nack_err}, {31'd0, |acks});
  endtask

  initial begin
    idle_inputs();
    data_in = 24'h0;
    reset = 1;
    SDO = 0;   // would drive SDA low if reset did not force sda_oe off
    repeat (3) tick();
    chk("rst_bitcount", {27'd0, bitcount}, 32'd0);
    chk("rst_ack_status", {29'd0, ack_status}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_xfer_cnt", {24'd0, xfer_cnt}, 32'd0);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    reset = 0;
    #1;
    chk("sdo_low_drives", {31'd0, sda_oe}, 32'd1);
    SDO = 1;
    #1;
    chk("sdo_high_releases", {31'd0, sda_oe}, 32'd0);
    tick();

    run_frame(24'h340E4A, 3'b000, 8'd1);
    run_frame(24'h340E4A, 3'b010, 8'd2);

    // Mid-frame reset at bitcount 12.
    data_in = 24'h340E4A;
    LDEN = 1;
    tick();
    LDEN = 0;
    SHEN = 1; bitcountEN = 1;
    repeat (12) tick();
    chk("pre_abort_bitcount", {27'd0, bitcount}, 32'd12);
    chk("nack_err_still_held", {31'd0, nack_err}, 32'd1);
    reset = 1;
    SHEN = 0; SDO = 0;
    #1;
    chk("abort_sda_oe_forced", {31'd0, sda_oe}, 32'd0);
    SHEN = 1;
    tick();
    chk("abort_bitcount", {27'd0, bitcount}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_xfer_cnt", {24'd0, xfer_cnt}, 32'd0);
    chk("abort_ack_status", {29'd0, ack_status}, 32'd0);
    reset = 0; SDO = 1;
    // Shift register must be all ones: never drives low across 27 shifts.
    for (int i = 0; i < 27; i++) begin
      #1;
      chk("abort_shreg_ones", {31'd0, sda_oe}, 32'd0);
      chk("abort_no_done", {31'd0, done}, 32'd0);
      tick();
    end
    idle_inputs();
    tick();

    // Back-to-back rstACK: one done per cycle, counter wraps after 256.
    rstACK = 1;
    for (int k = 1; k <= 255; k++) begin
      tick();
      chk("b2b_done", {31'd0, done}, 32'd1);
      chk("b2b_xfer_cnt", {24'd0, xfer_cnt}, k);
    end
    tick();
    rstACK = 0;
    #1;
    chk("wrap_xfer_cnt", {24'd0, xfer_cnt}, 32'd0);
    chk("wrap_done", {31'd0, done}, 32'd1);
    chk("wrap_ack_status", {29'd0, ack_status}, 32'd7);
    chk("wrap_nack_err", {31'd0, nack_err}, 32'd1);
    tick();
    chk("wrap_done_clear", {31'd0, done}, 32'd0);
    chk("wrap_xfer_hold", {24'd0, xfer_cnt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
